// File: rtl/dm_store_unit_pkg.sv
// Shared memory-op definitions for the data-memory store unit and the
// downstream load-extension block.
package dm_store_unit_pkg;

  typedef enum logic [3:0] {
    DM_NONE = 4'd0,
    DM_LW   = 4'd1,
    DM_LB   = 4'd2,
    DM_LBU  = 4'd3,
    DM_LH   = 4'd4,
    DM_LHU  = 4'd5,
    DM_SW   = 4'd6,
    DM_SH   = 4'd7,
    DM_SB   = 4'd8
  } dm_op_e;

  localparam int DM_LANES = 4;

endpackage

// File: rtl/dm_be_gen.sv
// Byte-enable, lane-replicated store data and address-error decode for one
// memory op. Purely combinational.
module dm_be_gen
  import dm_store_unit_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic        in_range,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        adel,
  output logic        ades
);

  // Decode op into error flags, lane enables and replicated write data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be    = '0;
    wdata = data;
    adel  = 1'b0;
    ades  = 1'b0;
    case (ctrl)
      DM_LW:         adel = (addr_lo != 2'b00) || !in_range;
      DM_LH, DM_LHU: adel = addr_lo[0] || !in_range;
      DM_LB, DM_LBU: adel = !in_range;
      DM_SW: begin
        ades = (addr_lo != 2'b00) || !in_range;
        be   = ades ? 4'b0000 : 4'b1111;
      end
      DM_SH: begin
        ades  = addr_lo[0] || !in_range;
        be    = ades ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
        wdata = {2{data[15:0]}};
      end
      DM_SB: begin
        ades  = !in_range;
        be    = ades ? 4'b0000 : (4'b0001 << addr_lo);
        wdata = {4{data[7:0]}};
      end
      default: ;  // DM_NONE and undefined codes: no access
    endcase
  end

endmodule

// File: rtl/dm_store_unit.sv
// M-stage data memory: word RAM with byte-lane store merging, combinational
// read of the aligned word, store counter and sticky address-error flag.
module dm_store_unit
  import dm_store_unit_pkg::*;
#(
  parameter int          ADDR_WORDS_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  input  logic [3:0]  ictrl,
  input  logic [31:0] iPC,
  output logic [31:0] out,
  output logic [3:0]  oBE,
  output logic        oAdEL,
  output logic        oAdES,
  output logic        oErrSticky,
  output logic [31:0] oStoreCnt
);

  localparam int          WORDS     = 1 << ADDR_WORDS_LOG2;
  localparam logic [31:0] BYTE_SPAN = 32'(WORDS * 4);

  logic [31:0]                mem [WORDS];
  logic [31:0]                offset;
  logic                       in_range;
  logic [ADDR_WORDS_LOG2-1:0] index;
  logic [31:0]                wdata;

  assign offset   = iAddr - BASE_ADDR;
  assign in_range = offset < BYTE_SPAN;
  assign index    = offset[ADDR_WORDS_LOG2+1:2];

  // Raw aligned word for the load-extension block; pre-store value in a store cycle.
  assign out = in_range ? mem[index] : 32'b0;

  // The PC only labels store traces and the low offset bits are taken from iAddr.
  logic unused_bits;
  assign unused_bits = ^{iPC, offset[1:0]};

  dm_be_gen u_be_gen (
    .ctrl     (ictrl),
    .addr_lo  (iAddr[1:0]),
    .in_range (in_range),
    .data     (iData),
    .be       (oBE),
    .wdata    (wdata),
    .adel     (oAdEL),
    .ades     (oAdES)
  );

  // Memory, store counter and sticky error: reset clears all, else merge enabled lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array itself is reset because a mid-program reset must leave no stale data.
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      oStoreCnt  <= '0;
      oErrSticky <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so the read path sees the pre-store word this cycle.
      if (oBE != 4'b0000) begin
        for (int k = 0; k < DM_LANES; k++) begin
          if (oBE[k]) mem[index][8*k +: 8] <= wdata[8*k +: 8];
        end
        oStoreCnt <= oStoreCnt + 32'd1;
      end
      if (oAdEL || oAdES) oErrSticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_store_unit.sv
// Self-checking bench for dm_store_unit: directed vector table plus
// randomized traffic against a byte-addressed reference model.
module tb_dm_store_unit;
  import dm_store_unit_pkg::*;

  localparam int unsigned MEM_BYTES = 32'h4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iAddr, iData, iPC;
  logic [3:0]  ictrl;
  logic [31:0] out;
  logic [3:0]  oBE;
  logic        oAdEL, oAdES, oErrSticky;
  logic [31:0] oStoreCnt;

  int tests  = 0;
  int failed = 0;
  logic [31:0] pc = 32'h0000_3000;

  dm_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .iAddr      (iAddr),
    .iData      (iData),
    .ictrl      (ictrl),
    .iPC        (iPC),
    .out        (out),
    .oBE        (oBE),
    .oAdEL      (oAdEL),
    .oAdES      (oAdES),
    .oErrSticky (oErrSticky),
    .oStoreCnt  (oStoreCnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0]  m_mem [MEM_BYTES];
  logic [31:0] m_cnt;
  logic        m_sticky;

  function automatic int unsigned m_size(input logic [3:0] op);
    case (op)
      DM_LW, DM_SW:          return 4;
      DM_LH, DM_LHU, DM_SH:  return 2;
      DM_LB, DM_LBU, DM_SB:  return 1;
      default:               return 0;
    endcase
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
  endfunction

  function automatic bit m_err(input logic [3:0] op, input logic [31:0] addr);
    int unsigned sz = m_size(op);
    if (sz == 0) return 1'b0;
    return ((addr % sz) != 0) || (addr >= MEM_BYTES);
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
    logic [3:0] be = '0;
    if (!m_is_store(op) || m_err(op, addr)) return be;
    for (int i = 0; i < int'(m_size(op)); i++) be[(addr % 4) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_out(input logic [31:0] addr);
    int unsigned b = addr & ~32'd3;
    if (addr >= MEM_BYTES) return 32'd0;
    return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_step();
    if (reset) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) m_mem[i] = 8'h00;
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else begin
      if (m_be(ictrl, iAddr) != 4'b0000) begin
        for (int i = 0; i < int'(m_size(ictrl)); i++) m_mem[iAddr + i] = iData[8*i +: 8];
        m_cnt = m_cnt + 1;
        $display("@%h: *%h <= %h", iPC, iAddr & ~32'd3, m_out(iAddr));
      end
      if (m_err(ictrl, iAddr)) m_sticky = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the active edge, then settle.
  task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic rst);
    @(negedge clk);
    ictrl = op; iAddr = addr; iData = data; reset = rst; iPC = pc;
    pc = pc + 4;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rst;
    logic [3:0]  be;
    logic        adel;
    logic        ades;
    logic [31:0] rd;
    logic [31:0] cnt;
    logic        sticky;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic rst, input logic [3:0] be, input logic adel, input logic ades,
                     input logic [31:0] rd, input logic [31:0] cnt, input logic sticky);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.rst = rst; v.be = be;
    v.adel = adel; v.ades = ades; v.rd = rd; v.cnt = cnt; v.sticky = sticky;
    vecs.push_back(v);
  endtask

  initial begin
    // op, addr, data, rst | be, adel, ades, out, cnt, sticky (sampled before the edge)
    add(DM_LW,   32'h0000, 32'h0,        0, 4'h0, 0, 0, 32'h0,        0, 0);
    add(DM_LW,   32'h3FFC, 32'h0,        0, 4'h0, 0, 0, 32'h0,        0, 0);
    add(DM_SW,   32'h0010, 32'h11223344, 0, 4'hF, 0, 0, 32'h0,        0, 0);
    add(DM_LW,   32'h0010, 32'h0,        0, 4'h0, 0, 0, 32'h11223344, 1, 0);
    add(DM_SW,   32'h0020, 32'hAABBCCDD, 0, 4'hF, 0, 0, 32'h0,        1, 0);
    add(DM_SB,   32'h0021, 32'h0000005A, 0, 4'h2, 0, 0, 32'hAABBCCDD, 2, 0);
    add(DM_SH,   32'h0022, 32'h00001234, 0, 4'hC, 0, 0, 32'hAABB5ADD, 3, 0);
    add(DM_LW,   32'h0020, 32'h0,        0, 4'h0, 0, 0, 32'h12345ADD, 4, 0);
    add(DM_SW,   32'h0022, 32'hCAFEF00D, 0, 4'h0, 0, 1, 32'h12345ADD, 4, 0);
    add(DM_SH,   32'h0023, 32'hCAFEF00D, 0, 4'h0, 0, 1, 32'h12345ADD, 4, 1);
    add(DM_LW,   32'h4000, 32'h0,        0, 4'h0, 1, 0, 32'h0,        4, 1);
    add(DM_LW,   32'h0020, 32'h0,        0, 4'h0, 0, 0, 32'h12345ADD, 4, 1);
    add(DM_SW,   32'h0030, 32'hFFFFFFFF, 1, 4'hF, 0, 0, 32'h0,        4, 1);
    add(DM_LW,   32'h0030, 32'h0,        0, 4'h0, 0, 0, 32'h0,        0, 0);
    add(DM_LW,   32'h0020, 32'h0,        0, 4'h0, 0, 0, 32'h0,        0, 0);
    add(DM_SW,   32'h0040, 32'hDEADBEEF, 0, 4'hF, 0, 0, 32'h0,        0, 0);
    add(DM_NONE, 32'h0040, 32'h0,        1, 4'h0, 0, 0, 32'hDEADBEEF, 1, 0);
    add(DM_LW,   32'h0040, 32'h0,        0, 4'h0, 0, 0, 32'h0,        0, 0);
    add(DM_SB,   32'h3FFF, 32'h00000077, 0, 4'h8, 0, 0, 32'h0,        0, 0);
    add(DM_LBU,  32'h3FFC, 32'h0,        0, 4'h0, 0, 0, 32'h77000000, 1, 0);
    add(4'hF,    32'h0003, 32'hFFFFFFFF, 0, 4'h0, 0, 0, 32'h0,        1, 0);
    add(DM_LHU,  32'h4001, 32'h0,        0, 4'h0, 1, 0, 32'h0,        1, 0);
    add(DM_NONE, 32'h3FFC, 32'h0,        0, 4'h0, 0, 0, 32'h77000000, 1, 1);

    // Initial reset, mirrored into the model.
    for (int i = 0; i < 2; i++) begin
      drive(DM_NONE, 32'h0, 32'h0, 1'b1);
      m_step();
    end

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rst);
      check($sformatf("vec%0d out", i),    out,        vecs[i].rd);
      check($sformatf("vec%0d be", i),     {28'd0, oBE}, {28'd0, vecs[i].be});
      check($sformatf("vec%0d adel", i),   {31'd0, oAdEL}, {31'd0, vecs[i].adel});
      check($sformatf("vec%0d ades", i),   {31'd0, oAdES}, {31'd0, vecs[i].ades});
      check($sformatf("vec%0d cnt", i),    oStoreCnt,  vecs[i].cnt);
      check($sformatf("vec%0d sticky", i), {31'd0, oErrSticky}, {31'd0, vecs[i].sticky});
      m_step();
    end

    // Randomized traffic against the model, concentrated on a few words and the top edge.
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic        rst;
      int unsigned sel;
      sel  = $urandom_range(0, 9);
      if (sel == 0)      addr = $urandom;
      else if (sel == 1) addr = 32'h3FF0 + $urandom_range(0, 31);
      else               addr = 32'h100 + $urandom_range(0, 31);
      op  = 4'($urandom_range(0, 10));
      rst = ($urandom_range(0, 99) == 0);
      drive(op, addr, $urandom, rst);
      check($sformatf("rnd%0d out", n),  out, m_out(addr));
      check($sformatf("rnd%0d be", n),   {28'd0, oBE}, {28'd0, m_be(op, addr)});
      check($sformatf("rnd%0d adel", n), {31'd0, oAdEL},
            {31'd0, (!m_is_store(op) && m_err(op, addr))});
      check($sformatf("rnd%0d ades", n), {31'd0, oAdES},
            {31'd0, (m_is_store(op) && m_err(op, addr))});
      check($sformatf("rnd%0d cnt", n),  oStoreCnt, m_cnt);
      check($sformatf("rnd%0d sticky", n), {31'd0, oErrSticky}, {31'd0, m_sticky});
      m_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
